// File: rtl/mux2_rr_arbiter.sv
// Two-requester arbiter for a shared 2:1 mux with burst-limited round-robin,
// feeding a one-entry valid/ready output register.

module mux2_rr_arbiter_port (
  input  logic i_rst_n,
  input  logic i_take,
  input  logic i_req,
  input  logic i_win_me,
  output logic o_gnt
);
  // Grant is purely combinational so it drops in the same cycle out_ready falls.
  assign o_gnt = i_rst_n && i_take && i_req && i_win_me;
endmodule

module mux2_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_e;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
    own_e             own;
    logic [CW-1:0]    cnt;
  } state_t;

  state_t                  r_st;
  state_t                  w_st_nxt;
  logic [1:0]              w_req;
  logic [1:0][WIDTH-1:0]   w_data;
  logic [1:0]              w_gnt;
  logic                    w_load_en;
  logic                    w_any;
  logic                    w_win;
  logic                    w_own;

  assign w_req     = {req1, req0};
  assign w_data    = {data1, data0};
  assign w_own     = logic'(r_st.own);
  assign w_load_en = !r_st.vld || out_ready;
  assign w_any     = |w_req;

  // Burst limit only matters under contention; a lone requester always wins.
  always_comb begin
    w_win = w_own;
    case (w_req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = (r_st.cnt < MAXC) ? w_own : ~w_own;
      default: w_win = w_own;
    endcase
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    mux2_rr_arbiter_port u_port (
      .i_rst_n  (rst_n),
      .i_take   (w_load_en),
      .i_req    (w_req[g]),
      .i_win_me (w_win == (g == 1)),
      .o_gnt    (w_gnt[g])
    );
  end

  // Owner FSM: OWN0/OWN1 with a saturating burst counter; idle cycles keep burst state.
  always_comb begin
    w_st_nxt = r_st;
    if (w_load_en) begin
      if (w_any) begin
        w_st_nxt.vld  = 1'b1;
        w_st_nxt.data = w_data[w_win];
        if (w_win == w_own) begin
          w_st_nxt.cnt = (r_st.cnt >= MAXC) ? MAXC : r_st.cnt + ONE;
        end else begin
          w_st_nxt.own = own_e'(w_win);
          w_st_nxt.cnt = ONE;
        end
      end else begin
        w_st_nxt.vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= '0;
    else        r_st <= w_st_nxt;
  end

  assign gnt0      = w_gnt[0];
  assign gnt1      = w_gnt[1];
  assign out_valid = r_st.vld;
  assign out_data  = r_st.data;
  assign sel       = w_own;
endmodule
